// File: rtl/registro_pkg.sv
// registro_pkg
// Shared types for the registro_shift_seq operand register family.
//   op_t    : 3-bit operation code as presented on the op input.
//   state_t : sequencer states of the multi-cycle shift engine.
package registro_pkg;

  typedef enum logic [2:0] {
    HOLD  = 3'b000,
    LOAD  = 3'b001,
    CLEAR = 3'b010,
    SHL   = 3'b011,
    SHR   = 3'b100,
    SAR   = 3'b101,
    ROL   = 3'b110,
    ROR   = 3'b111
  } op_t;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  // True for the five opcodes that move bits one position per step.
  function automatic logic isShiftOp(input op_t opVal);
    return (opVal == SHL) || (opVal == SHR) || (opVal == SAR) ||
           (opVal == ROL) || (opVal == ROR);
  endfunction

endpackage

// File: rtl/registro_shift_step.sv
// registro_shift_step
// Purely combinational single-position shifter/rotator.
// Ports:
//   z_i    : current register contents (N bits)
//   sin_i  : serial fill bit used by SHL and SHR
//   op_i   : operation to apply for this step
//   cout_i : current carry, passed through for non-shift opcodes
//   z_o    : contents after one step
//   cout_o : bit moved out by this step
module registro_shift_step
  import registro_pkg::*;
#(
  parameter int N = 8
) (
  input  logic [N-1:0] z_i,
  input  logic         sin_i,
  input  op_t          op_i,
  input  logic         cout_i,
  output logic [N-1:0] z_o,
  output logic         cout_o
);

  // Non-shift opcodes never reach this block in practice; they simply
  // pass the register and carry through so the outputs are always defined.
  always_comb begin
    z_o    = z_i;
    cout_o = cout_i;
    unique case (op_i)
      SHL: begin
        z_o    = {z_i[N-2:0], sin_i};
        cout_o = z_i[N-1];
      end
      SHR: begin
        z_o    = {sin_i, z_i[N-1:1]};
        cout_o = z_i[0];
      end
      SAR: begin
        z_o    = {z_i[N-1], z_i[N-1:1]};
        cout_o = z_i[0];
      end
      ROL: begin
        z_o    = {z_i[N-2:0], z_i[N-1]};
        cout_o = z_i[N-1];
      end
      ROR: begin
        z_o    = {z_i[0], z_i[N-1:1]};
        cout_o = z_i[0];
      end
      default: begin
        z_o    = z_i;
        cout_o = cout_i;
      end
    endcase
  end

endmodule

// File: rtl/registro_shift_seq.sv
// registro_shift_seq
// N-bit operand register that loads, clears, shifts and rotates. Multi-bit
// shifts are executed one position per clock under a start/busy/done
// handshake.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   x     : parallel load value
//   op    : operation code, sampled when a start is accepted
//   amt   : shift/rotate amount, sampled with op
//   sin   : serial fill bit for SHL/SHR, sampled on every step
//   start : operation request, honoured only in IDLE
//   z     : register contents
//   cout  : last bit shifted or rotated out
//   zf    : high while z is all zeros
//   busy  : high whenever the sequencer is not IDLE
//   done  : high for the single DONE cycle
module registro_shift_seq
  import registro_pkg::*;
#(
  parameter int N  = 8,
  parameter int SW = $clog2(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  x,
  input  logic [2:0]    op,
  input  logic [SW-1:0] amt,
  input  logic          sin,
  input  logic          start,
  output logic [N-1:0]  z,
  output logic          cout,
  output logic          zf,
  output logic          busy,
  output logic          done
);

  localparam bit IS_POW2 = (N == (1 << SW));

  state_t        state_q, state_d;
  op_t           op_q, op_d;
  logic [SW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  z_q, z_d;
  logic          cout_q, cout_d;

  logic [SW-1:0] amtClamped;
  logic [N-1:0]  stepZ;
  logic          stepCout;
  op_t           opIn;

  assign opIn = op_t'(op);

  // When N is a power of two every encodable amount is legal; otherwise
  // amounts past N-1 saturate at N-1.
  generate
    if (IS_POW2) begin : g_noClamp
      assign amtClamped = amt;
    end else begin : g_clamp
      assign amtClamped = (amt > SW'(N - 1)) ? SW'(N - 1) : amt;
    end
  endgenerate

  // One-step shifter, always driven by the latched opcode so that op
  // changes after acceptance cannot disturb a running shift.
  registro_shift_step #(.N(N)) u_step (
    .z_i    (z_q),
    .sin_i  (sin),
    .op_i   (op_q),
    .cout_i (cout_q),
    .z_o    (stepZ),
    .cout_o (stepCout)
  );

  // State, counter, latched opcode and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      op_q    <= HOLD;
      cnt_q   <= '0;
      z_q     <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      z_q     <= z_d;
      cout_q  <= cout_d;
    end
  end

  // Next-state logic. Single-cycle operations finish at the acceptance
  // edge and go straight to DONE; shifts with a nonzero amount walk through
  // RUN, leaving on the step that takes the counter from 1 to 0.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    z_d     = z_q;
    cout_d  = cout_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d = opIn;
          unique case (opIn)
            LOAD: begin
              z_d     = x;
              state_d = DONE;
            end
            CLEAR: begin
              z_d     = '0;
              state_d = DONE;
            end
            HOLD: begin
              state_d = DONE;
            end
            default: begin
              if (isShiftOp(opIn) && (amtClamped != '0)) begin
                cnt_d   = amtClamped;
                state_d = RUN;
              end else begin
                state_d = DONE;
              end
            end
          endcase
        end
      end
      RUN: begin
        z_d    = stepZ;
        cout_d = stepCout;
        cnt_d  = cnt_q - SW'(1);
        if (cnt_q == SW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign z    = z_q;
  assign cout = cout_q;
  assign zf   = (z_q == '0);
  assign busy = (state_q != IDLE);
  assign done = (state_q == DONE);

endmodule

// File: tb/tb_registro_shift_seq.sv
// tb_registro_shift_seq
// Directed bench for registro_shift_seq with N = 8. Inputs change on the
// falling edge; outputs are sampled on the falling edge after each rising
// edge, so every check sees settled post-edge values.
module tb_registro_shift_seq;

  localparam int N  = 8;
  localparam int SW = 3;

  localparam logic [2:0] OP_HOLD  = 3'b000;
  localparam logic [2:0] OP_LOAD  = 3'b001;
  localparam logic [2:0] OP_CLEAR = 3'b010;
  localparam logic [2:0] OP_SHL   = 3'b011;
  localparam logic [2:0] OP_SAR   = 3'b101;
  localparam logic [2:0] OP_ROL   = 3'b110;
  localparam logic [2:0] OP_ROR   = 3'b111;

  logic          clk;
  logic          rst_n;
  logic [N-1:0]  x;
  logic [2:0]    op;
  logic [SW-1:0] amt;
  logic          sin;
  logic          start;
  logic [N-1:0]  z;
  logic          cout;
  logic          zf;
  logic          busy;
  logic          done;

  int testCount;
  int failCount;

  registro_shift_seq #(.N(N), .SW(SW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x),
    .op    (op),
    .amt   (amt),
    .sin   (sin),
    .start (start),
    .z     (z),
    .cout  (cout),
    .zf    (zf),
    .busy  (busy),
    .done  (done)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Presents one request for a single cycle. Returns on the falling edge
  // right after the acceptance edge E0.
  task automatic applyStimulus(input logic [2:0] opVal, input logic [SW-1:0] amtVal,
                               input logic [N-1:0] xVal, input logic sinVal);
    @(negedge clk);
    op    = opVal;
    amt   = amtVal;
    x     = xVal;
    sin   = sinVal;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Checks one post-edge snapshot of z, cout, busy and done.
  task automatic checkStep(input string tag, input logic [N-1:0] zExp,
                           input logic coutExp, input logic busyExp,
                           input logic doneExp);
    checkOutput({tag, " z"},    32'(z),    32'(zExp));
    checkOutput({tag, " cout"}, 32'(cout), 32'(coutExp));
    checkOutput({tag, " busy"}, 32'(busy), 32'(busyExp));
    checkOutput({tag, " done"}, 32'(done), 32'(doneExp));
  endtask

  initial begin
    testCount = 0;
    failCount = 0;
    rst_n = 1'b0;
    start = 1'b0;
    op    = OP_HOLD;
    amt   = '0;
    x     = '0;
    sin   = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Reset while holding 0x5A
    applyStimulus(OP_LOAD, 3'd0, 8'h5A, 1'b0);
    checkStep("preload", 8'h5A, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkStep("reset", 8'h00, 1'b0, 1'b0, 1'b0);
    checkOutput("reset zf", 32'(zf), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkStep("after reset", 8'h00, 1'b0, 1'b0, 1'b0);

    // LOAD 0xA5
    applyStimulus(OP_LOAD, 3'd0, 8'hA5, 1'b0);
    checkStep("load E0", 8'hA5, 1'b0, 1'b1, 1'b1);
    checkOutput("load zf", 32'(zf), 32'd0);
    @(negedge clk);
    checkStep("load E1", 8'hA5, 1'b0, 1'b0, 1'b0);

    // SHL by 3 with an ignored LOAD 0xFF request and x change mid-run
    applyStimulus(OP_SHL, 3'd3, 8'hA5, 1'b0);
    checkStep("shl E0", 8'hA5, 1'b0, 1'b1, 1'b0);
    op    = OP_LOAD;
    x     = 8'hFF;
    amt   = 3'd0;
    start = 1'b1;
    @(negedge clk);
    checkStep("shl E1", 8'h4A, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkStep("shl E2", 8'h94, 1'b0, 1'b1, 1'b0);
    checkOutput("shl run zf", 32'(zf), 32'd0);
    start = 1'b0;
    @(negedge clk);
    checkStep("shl E3", 8'h28, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkStep("shl E4", 8'h28, 1'b1, 1'b0, 1'b0);

    // ROL by 0: immediate DONE, z and cout untouched
    applyStimulus(OP_ROL, 3'd0, 8'h00, 1'b0);
    checkStep("rol0 E0", 8'h28, 1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkStep("rol0 E1", 8'h28, 1'b1, 1'b0, 1'b0);

    // LOAD keeps cout, then SAR by 2
    applyStimulus(OP_LOAD, 3'd0, 8'h85, 1'b0);
    checkStep("load85", 8'h85, 1'b1, 1'b1, 1'b1);
    applyStimulus(OP_SAR, 3'd2, 8'h00, 1'b0);
    @(negedge clk);
    checkStep("sar E1", 8'hC2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkStep("sar E2", 8'hE1, 1'b0, 1'b1, 1'b1);

    // ROR by 4 from 0xA5
    applyStimulus(OP_LOAD, 3'd0, 8'hA5, 1'b0);
    applyStimulus(OP_ROR, 3'd4, 8'h00, 1'b0);
    @(negedge clk);
    checkStep("ror E1", 8'hD2, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkStep("ror E2", 8'h69, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkStep("ror E3", 8'hB4, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkStep("ror E4", 8'h5A, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkStep("ror E5", 8'h5A, 1'b0, 1'b0, 1'b0);

    // ROL by 1, SHL by 1 with sin = 1, then CLEAR and HOLD
    applyStimulus(OP_ROL, 3'd1, 8'h00, 1'b0);
    @(negedge clk);
    checkStep("rol1", 8'hB4, 1'b0, 1'b1, 1'b1);
    applyStimulus(OP_SHL, 3'd1, 8'h00, 1'b1);
    @(negedge clk);
    checkStep("shl sin1", 8'h69, 1'b1, 1'b1, 1'b1);
    applyStimulus(OP_CLEAR, 3'd0, 8'hFF, 1'b0);
    checkStep("clear", 8'h00, 1'b1, 1'b1, 1'b1);
    checkOutput("clear zf", 32'(zf), 32'd1);
    applyStimulus(OP_HOLD, 3'd5, 8'hFF, 1'b1);
    checkStep("hold", 8'h00, 1'b1, 1'b1, 1'b1);

    // Asynchronous reset in the middle of a run, then a fresh LOAD
    applyStimulus(OP_LOAD, 3'd0, 8'hA5, 1'b0);
    applyStimulus(OP_SHL, 3'd3, 8'h00, 1'b0);
    @(negedge clk);
    checkStep("pre-abort", 8'h4A, 1'b1, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    checkStep("abort", 8'h00, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(OP_LOAD, 3'd0, 8'h3C, 1'b0);
    checkStep("reload", 8'h3C, 1'b0, 1'b1, 1'b1);
    @(negedge clk);
    checkStep("reload E1", 8'h3C, 1'b0, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
